// File: rtl/uart_move_parser.sv
// uart_move_parser: parses ASCII cube moves from a UART byte stream into a FWFT move FIFO
module uart_move_parser #(
    parameter int DEPTH        = 16,
    parameter int TIMEOUT_CLKS = 200000
) (
    input  logic                         I_sys_clk,
    input  logic                         I_rst,
    input  logic [7:0]                   I_rx_data,
    input  logic                         I_rx_data_valid,
    input  logic                         I_move_ready,
    output logic                         o_move_valid,
    output logic [2:0]                   o_move_face,
    output logic [1:0]                   o_move_turn,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count,
    output logic                         o_overflow,
    output logic [7:0]                   o_err_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;
    logic [0:0]    state, nxt_state;
    logic [2:0]    face_q, nxt_face, byte_face;
    logic [TW-1:0] timer, nxt_timer;
    logic          is_face, is_prime, is_two, is_sep;
    logic          push, do_push, pop, err_inc;
    logic [1:0]    push_turn;
    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    // classify the incoming byte and map face letters to their codes
    always_comb begin
        byte_face = I_rx_data == 8'h55 ? 3'd0 :
                    I_rx_data == 8'h44 ? 3'd1 :
                    I_rx_data == 8'h4C ? 3'd2 :
                    I_rx_data == 8'h52 ? 3'd3 :
                    I_rx_data == 8'h46 ? 3'd4 : 3'd5;
        is_face   = I_rx_data inside {8'h55, 8'h44, 8'h4C, 8'h52, 8'h46, 8'h42};
        is_prime  = I_rx_data == 8'h27;
        is_two    = I_rx_data == 8'h32;
        is_sep    = I_rx_data inside {8'h20, 8'h2C, 8'h0D, 8'h0A};
    end
    // parser next state: a byte always beats the idle timeout in the same cycle
    always_comb begin
        push      = 1'b0;
        push_turn = 2'b01;
        nxt_state = state;
        nxt_face  = face_q;
        nxt_timer = timer;
        err_inc   = 1'b0;
        if (I_rx_data_valid) begin
            nxt_timer = '0;
            if (state == IDLE) begin
                nxt_state = is_face ? PEND : IDLE;
                nxt_face  = is_face ? byte_face : face_q;
                err_inc   = !is_face && !is_sep;
            end else begin
                push      = 1'b1;
                push_turn = is_prime ? 2'b11 : is_two ? 2'b10 : 2'b01;
                nxt_state = is_face ? PEND : IDLE;
                nxt_face  = is_face ? byte_face : face_q;
                err_inc   = !(is_face || is_prime || is_two || is_sep);
            end
        end else if (state == PEND) begin
            if (timer == TW'(TIMEOUT_CLKS - 1)) begin
                push      = 1'b1;
                nxt_state = IDLE;
                nxt_timer = '0;
            end else begin
                nxt_timer = timer + 1'b1;
            end
        end
    end
    assign pop          = o_move_valid && I_move_ready;
    assign do_push      = push && (o_fifo_count != CW'(DEPTH));
    assign o_move_valid = o_fifo_count != '0;
    assign {o_move_face, o_move_turn} = o_move_valid ? mem[rd_ptr] : 5'd0;
    // parser state, pending face and idle timer
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state  <= IDLE;
            face_q <= '0;
            timer  <= '0;
        end else begin
            state  <= nxt_state;
            face_q <= nxt_face;
            timer  <= nxt_timer;
        end
    end
    // move storage; contents need no reset since count gates visibility
    always_ff @(posedge I_sys_clk) begin
        if (do_push)
            mem[wr_ptr] <= {face_q, push_turn};
    end
    // FIFO pointers, occupancy, sticky overflow and saturating error count
    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            o_fifo_count <= '0;
            o_overflow   <= 1'b0;
            o_err_count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            o_fifo_count <= (do_push && !pop) ? o_fifo_count + 1'b1 :
                            (pop && !do_push) ? o_fifo_count - 1'b1 : o_fifo_count;
            if (push && !do_push)
                o_overflow <= 1'b1;
            if (err_inc && o_err_count != 8'hFF)
                o_err_count <= o_err_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_move_parser.sv
// tb_uart_move_parser: randomized and directed checks of uart_move_parser against a byte-level model
module tb_uart_move_parser;
    localparam int DEPTH = 4;
    localparam int TMO   = 50;
    logic       clk = 1'b0;
    logic       I_rst = 1'b1;
    logic [7:0] I_rx_data = 8'h00;
    logic       I_rx_data_valid = 1'b0;
    logic       I_move_ready = 1'b0;
    logic       o_move_valid, o_overflow;
    logic [2:0] o_move_face, o_fifo_count;
    logic [1:0] o_move_turn;
    logic [7:0] o_err_count;
    logic [17:0] obs;
    int nvec = 0, nerr = 0;
    logic [4:0] mq[$];
    logic [4:0] got_q[$];
    int   pend = -1, idle = 0, merr = 0;
    logic movf = 1'b0;

    uart_move_parser #(.DEPTH(DEPTH), .TIMEOUT_CLKS(TMO)) dut (
        .I_sys_clk(clk), .I_rst(I_rst), .I_rx_data(I_rx_data),
        .I_rx_data_valid(I_rx_data_valid), .I_move_ready(I_move_ready),
        .o_move_valid(o_move_valid), .o_move_face(o_move_face), .o_move_turn(o_move_turn),
        .o_fifo_count(o_fifo_count), .o_overflow(o_overflow), .o_err_count(o_err_count)
    );

    always #5 clk = ~clk;
    assign obs = {o_move_valid, o_move_face, o_move_turn, o_fifo_count, o_overflow, o_err_count};

    function automatic int face_of(input logic [7:0] b);
        string s = "UDLRFB";
        for (int i = 0; i < 6; i++)
            if (s[i] == b) return i;
        return -1;
    endfunction

    function automatic logic [17:0] expv();
        logic [4:0] head = mq.size() != 0 ? mq[0] : 5'd0;
        return {mq.size() != 0, head, 3'(mq.size()), movf, 8'(merr)};
    endfunction

    // one clock of stimulus followed by the model's view of the same cycle
    task automatic step(input logic v, input logic [7:0] b, input logic rdy, input logic r);
        bit push, full, pop, sep, suffix;
        int f;
        logic [4:0] ent;
        I_rx_data_valid = v; I_rx_data = b; I_move_ready = rdy; I_rst = r;
        if (!r && o_move_valid && rdy) got_q.push_back({o_move_face, o_move_turn});
        @(posedge clk);
        if (r) begin
            mq.delete(); pend = -1; idle = 0; merr = 0; movf = 1'b0;
        end else begin
            full = mq.size() == DEPTH;
            pop  = rdy && mq.size() != 0;
            push = 1'b0;
            f    = face_of(b);
            sep  = b == 8'h20 || b == 8'h2C || b == 8'h0D || b == 8'h0A;
            suffix = b == 8'h27 || b == 8'h32;
            ent  = 5'd0;
            if (v) begin
                idle = 0;
                if (pend < 0) begin
                    if (f >= 0) pend = f;
                    else if (!sep) merr = merr < 255 ? merr + 1 : 255;
                end else begin
                    push = 1'b1;
                    ent  = {3'(pend), b == 8'h27 ? 2'b11 : b == 8'h32 ? 2'b10 : 2'b01};
                    if (f < 0 && !sep && !suffix) merr = merr < 255 ? merr + 1 : 255;
                    pend = f;
                end
            end else if (pend >= 0) begin
                idle++;
                if (idle == TMO) begin
                    push = 1'b1; ent = {3'(pend), 2'b01}; pend = -1; idle = 0;
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) begin
                if (full) movf = 1'b1;
                else mq.push_back(ent);
            end
        end
        #1;
    endtask

    task automatic send(input string s, input logic rdy);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i], rdy, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, "x", 1'b0, 1'b1);
        nvec++;
        if (obs !== 18'd0) begin nerr++; $display("FAIL reset_outputs: got %h want 0", obs); end
        step(1'b1, "R", 1'b1, 1'b1);
        for (int i = 0; i < TMO + 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        nvec++;
        if (obs !== expv() || o_move_valid !== 1'b0 || o_err_count !== 8'd0)
            begin nerr++; $display("FAIL reset_byte_ignored: got %h want %h", obs, expv()); end
    endtask

    task automatic test_stream();
        logic [4:0] want[3] = '{5'b011_01, 5'b000_11, 5'b100_10};
        step(1'b0, 8'h00, 1'b0, 1'b1);
        got_q.delete();
        send("R U' F2 ", 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            nvec++;
            if (obs !== expv()) begin nerr++; $display("FAIL stream_model: got %h want %h", obs, expv()); end
        end
        for (int i = 0; i < 3; i++) begin
            nvec++;
            if ((i < got_q.size() ? got_q[i] : 5'bx) !== want[i])
                begin nerr++; $display("FAIL stream_order[%0d]: got %b want %b", i, i < got_q.size() ? got_q[i] : 5'bx, want[i]); end
        end
        nvec++;
        if (got_q.size() != 3 || o_err_count !== 8'd0 || o_fifo_count !== 3'd0)
            begin nerr++; $display("FAIL stream_end: moves %0d err %0d count %0d want 3 0 0", got_q.size(), o_err_count, o_fifo_count); end
    endtask

    task automatic test_timeout();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        send("RL", 1'b0);
        nvec++;
        if (o_fifo_count !== 3'd1 || o_move_face !== 3'd3 || o_move_turn !== 2'b01)
            begin nerr++; $display("FAIL timeout_first: got count %0d head %0d/%b want 1 3/01", o_fifo_count, o_move_face, o_move_turn); end
        for (int i = 0; i < TMO - 1; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        nvec++;
        if (o_fifo_count !== 3'd1) begin nerr++; $display("FAIL timeout_early: got count %0d want 1", o_fifo_count); end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        nvec++;
        if (o_fifo_count !== 3'd2 || obs !== expv()) begin nerr++; $display("FAIL timeout_fire: got count %0d want 2", o_fifo_count); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        nvec++;
        if (o_move_face !== 3'd2 || o_move_turn !== 2'b01) begin nerr++; $display("FAIL timeout_head: got %0d/%b want 2/01", o_move_face, o_move_turn); end
    endtask

    task automatic test_errors();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        send("'x2r", 1'b0);
        nvec++;
        if (o_err_count !== 8'd4 || o_move_valid !== 1'b0) begin nerr++; $display("FAIL err_idle: got err %0d valid %b want 4 0", o_err_count, o_move_valid); end
        send("F?", 1'b0);
        nvec++;
        if (o_err_count !== 8'd5 || o_move_face !== 3'd4 || o_move_turn !== 2'b01 || o_fifo_count !== 3'd1)
            begin nerr++; $display("FAIL err_pend: got err %0d head %0d/%b want 5 4/01", o_err_count, o_move_face, o_move_turn); end
        for (int i = 0; i < 260; i++) step(1'b1, "x", 1'b0, 1'b0);
        nvec++;
        if (o_err_count !== 8'd255 || obs !== expv()) begin nerr++; $display("FAIL err_saturate: got %0d want 255", o_err_count); end
    endtask

    task automatic test_overflow();
        logic [4:0] want[4] = '{5'b000_01, 5'b001_01, 5'b010_01, 5'b011_01};
        step(1'b0, 8'h00, 1'b0, 1'b1);
        got_q.delete();
        send("U D L R F ", 1'b0);
        nvec++;
        if (o_fifo_count !== 3'd4 || o_overflow !== 1'b1) begin nerr++; $display("FAIL ovf_full: got count %0d ovf %b want 4 1", o_fifo_count, o_overflow); end
        for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if ((i < got_q.size() ? got_q[i] : 5'bx) !== want[i])
                begin nerr++; $display("FAIL ovf_order[%0d]: got %b want %b", i, i < got_q.size() ? got_q[i] : 5'bx, want[i]); end
        end
        nvec++;
        if (got_q.size() != 4 || o_overflow !== 1'b1 || o_move_valid !== 1'b0)
            begin nerr++; $display("FAIL ovf_sticky: moves %0d ovf %b valid %b want 4 1 0", got_q.size(), o_overflow, o_move_valid); end
    endtask

    task automatic test_back_to_back();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        send("UDLR", 1'b0);
        send("F", 1'b0);
        nvec++;
        if (o_fifo_count !== 3'd4 || o_overflow !== 1'b0) begin nerr++; $display("FAIL b2b_fill: got count %0d ovf %b want 4 0", o_fifo_count, o_overflow); end
        step(1'b1, "B", 1'b1, 1'b0);
        nvec++;
        if (o_fifo_count !== 3'd3 || o_overflow !== 1'b1 || o_move_face !== 3'd1)
            begin nerr++; $display("FAIL b2b_full_pushpop: got count %0d ovf %b head %0d want 3 1 1", o_fifo_count, o_overflow, o_move_face); end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        nvec++;
        if (o_fifo_count !== 3'd2 || o_move_face !== 3'd2) begin nerr++; $display("FAIL b2b_pop: got count %0d head %0d want 2 2", o_fifo_count, o_move_face); end
        step(1'b1, "2", 1'b1, 1'b0);
        nvec++;
        if (o_fifo_count !== 3'd2 || o_move_face !== 3'd3 || obs !== expv())
            begin nerr++; $display("FAIL b2b_pushpop: got count %0d head %0d want 2 3", o_fifo_count, o_move_face); end
    endtask

    task automatic test_reset_midparse();
        step(1'b0, 8'h00, 1'b0, 1'b1);
        send("B", 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        nvec++;
        if (obs !== 18'd0) begin nerr++; $display("FAIL midparse_reset: got %h want 0", obs); end
        send("2", 1'b0);
        for (int i = 0; i < TMO + 2; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
        nvec++;
        if (o_err_count !== 8'd1 || o_move_valid !== 1'b0) begin nerr++; $display("FAIL midparse_two: got err %0d valid %b want 1 0", o_err_count, o_move_valid); end
    endtask

    task automatic test_random();
        logic [7:0] pool[14] = '{"U", "D", "L", "R", "F", "B", 8'h27, 8'h32, 8'h20, 8'h2C, 8'h0D, 8'h0A, "x", "u"};
        logic [7:0] b;
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int n = 0; n < 1500; n++) begin
            b = $urandom_range(0, 9) == 0 ? 8'($urandom) : pool[$urandom_range(0, 13)];
            if ($urandom_range(0, 40) == 0)
                for (int i = 0; i < TMO + 3; i++) step(1'b0, 8'h00, $urandom_range(0, 3) == 0, 1'b0);
            step($urandom_range(0, 2) == 0, b, $urandom_range(0, 2) != 0, $urandom_range(0, 300) == 0);
            nvec++;
            if (obs !== expv()) begin nerr++; $display("FAIL random[%0d]: got %h want %h", n, obs, expv()); end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_timeout();
        test_errors();
        test_overflow();
        test_back_to_back();
        test_reset_midparse();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/uart_move_parser.md
Name: uart_move_parser

Overview:
Downstream consumer of the UART receive wrapper's byte stream (o_read_data / o_read_data_valid). Parses ASCII cube-move notation (faces U D L R F B, optional suffix ' or 2) into encoded move tokens. Buffers the tokens in a FIFO and hands them to the cube-state/move engine through a valid/ready handshake. Counts malformed input and flags FIFO overflow.

Parameters:
DEPTH, 16, move FIFO entries; power of two, 2..256.
TIMEOUT_CLKS, 200000, idle clocks after a face letter before the pending move commits as CW (about 2 ms at 100 MHz); must be >= 2.

Ports:
I_sys_clk  in  1  system clock; all logic on rising edge.
I_rst  in  1  synchronous, active-high reset.
I_rx_data  in  8  received byte; sampled only when I_rx_data_valid = 1.
I_rx_data_valid  in  1  single-cycle byte strobe from the UART RX stage.
I_move_ready  in  1  consumer ready to accept the head move.
o_move_valid  out  1  FIFO non-empty; head move presented.
o_move_face  out  3  head face code: U=0, D=1, L=2, R=3, F=4, B=5.
o_move_turn  out  2  head turn code: 01 = CW, 10 = 180, 11 = CCW; 00 never emitted.
o_fifo_count  out  clog2(DEPTH+1)  current FIFO occupancy.
o_overflow  out  1  sticky; set when a move is dropped because the FIFO is full.
o_err_count  out  8  malformed-byte count; saturates at 255.

Behaviour:
- Reset (sync, I_rst=1 at an edge): state=IDLE; FIFO empty; timeout counter=0; o_move_valid=0, o_fifo_count=0, o_overflow=0, o_err_count=0. o_move_face and o_move_turn read 0. A byte strobed in a reset cycle is ignored. Reset mid-parse discards the pending face.
- Byte classes: FACE = 'U' 'D' 'L' 'R' 'F' 'B' (0x55 0x44 0x4C 0x52 0x46 0x42, uppercase only). PRIME = 0x27. TWO = 0x32. SEP = space 0x20, ',' 0x2C, CR 0x0D, LF 0x0A. OTHER = any other byte, including lowercase letters.
- FSM IDLE (no pending face):
  - FACE: latch face; go to PEND.
  - SEP: stay in IDLE.
  - PRIME, TWO, OTHER: err+1; stay in IDLE.
- FSM PEND (face latched; timeout counter runs):
  - PRIME: push (face, CCW); go to IDLE.
  - TWO: push (face, 180); go to IDLE.
  - FACE: push (old face, CW); latch new face; stay in PEND; counter=0.
  - SEP: push (face, CW); go to IDLE.
  - OTHER: push (face, CW); err+1; go to IDLE.
  - No byte and counter = TIMEOUT_CLKS-1: push (face, CW); go to IDLE.
  - Counter resets to 0 on entry to PEND and on every accepted byte.
  - A byte arriving in the same cycle the timeout would fire takes priority; the timeout does not fire.
- At most one push per cycle.
- FIFO (first-word-fall-through):
  - o_move_valid = (count != 0). Face and turn are driven from the head entry.
  - Pop occurs when o_move_valid & I_move_ready.
  - Push is dropped if count == DEPTH at the start of the cycle, even if a pop occurs in the same cycle. A dropped push sets o_overflow.
  - Simultaneous push and pop with count in 1..DEPTH-1: count is unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Latency: a strobe at edge N that causes a push into an empty FIFO gives o_move_valid=1 with the correct head after edge N (visible in cycle N+1).
- Consumer contract: head face and turn are stable while o_move_valid=1 and no pop occurs. I_move_ready with an empty FIFO has no effect.
- o_err_count saturates at 255 and does not wrap.

Test Plan:
- Stream "R U' F2 " (TIMEOUT_CLKS=50), I_move_ready=1 -> three moves in order: (3,01), (0,11), (4,10); o_err_count=0; FIFO empty at the end.
- Bytes "RL" then idle for 50 clocks, TIMEOUT_CLKS=50 -> (3,01) pushed on the 'L' byte; (2,01) pushed exactly 50 clocks after the 'L' strobe.
- Bytes "'", "x", "2", "r" starting in IDLE -> no moves; o_err_count=4. Then "F" followed by "?" -> (4,01) pushed; o_err_count=5.
- DEPTH=4, I_move_ready=0, send "U D L R F " -> o_fifo_count=4; o_overflow=1; pop order U, D, L, R; F is lost. o_overflow stays 1 until reset.
- FIFO full plus a push coinciding with a pop -> push dropped; count goes to 3. With count=2, push and pop in the same cycle -> count stays 2 and the head advances.
- Assert I_rst after the 'B' byte of "B2" and hold it for one cycle; next byte is "2" -> no move; o_err_count=1 (a PRIME/TWO byte in IDLE is an error). All outputs are zero during reset.
